// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: an OUT slot feeding Execute, backed by a one-entry skid slot, so
// in_ready depends only on registered state. Also has a pipeline flush and a saturating stall counter.
module idex_pipe_reg #(
    parameter int XLEN      = 32,
    parameter int REGADDR_W = 5,
    parameter int CTRL_W    = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [XLEN-1:0]      in_op_a,
    input  logic [XLEN-1:0]      in_op_b,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [REGADDR_W-1:0] in_rd,
    input  logic [CTRL_W-1:0]    in_ctrl,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_op_a,
    output logic [XLEN-1:0]      ex_op_b,
    output logic [XLEN-1:0]      ex_imm,
    output logic [REGADDR_W-1:0] ex_rd,
    output logic [CTRL_W-1:0]    ex_ctrl,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int PW = 4 * XLEN + REGADDR_W + CTRL_W;

    logic          r_outValid;
    logic          r_skidValid;
    logic [PW-1:0] r_outPay;
    logic [PW-1:0] r_skidPay;
    logic [CNT_W-1:0] r_stallCnt;

    logic          w_accept;
    logic          w_drain;
    logic [PW-1:0] w_inPay;

    assign in_ready = ~reset & ~r_skidValid;
    assign w_accept = in_valid & in_ready;
    assign w_drain  = r_outValid & ex_ready;
    assign w_inPay  = {in_pc, in_op_a, in_op_b, in_imm, in_rd, in_ctrl};

    assign ex_valid  = r_outValid;
    assign {ex_pc, ex_op_a, ex_op_b, ex_imm, ex_rd, ex_ctrl} = r_outPay;
    assign stall_cnt = r_stallCnt;

    // The skid slot only fills when OUT is stalled, so it never holds data while OUT is empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_outValid  <= 1'b0;
            r_skidValid <= 1'b0;
            r_outPay    <= '0;
            r_skidPay   <= '0;
        end else if (flush) begin
            r_outValid  <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (!r_outValid || w_drain) begin
            if (r_skidValid) begin
                r_outPay    <= r_skidPay;
                r_outValid  <= 1'b1;
                r_skidValid <= 1'b0;
            end else if (w_accept) begin
                r_outPay    <= w_inPay;
                r_outValid  <= 1'b1;
            end else begin
                r_outValid  <= 1'b0;
            end
        end else if (w_accept) begin
            r_skidPay   <= w_inPay;
            r_skidValid <= 1'b1;
        end
    end

    // Counts every stalled cycle, flush cycles included, and sticks at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stallCnt <= '0;
        end else if (r_outValid && !ex_ready && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Testbench for idex_pipe_reg: directed vector table, stall-counter saturation,
// and a randomized run checked against an in-order queue model.
module tb_idex_pipe_reg;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready, ex_valid, ex_ready;
    logic [31:0] in_pc, in_op_a, in_op_b, in_imm;
    logic [4:0]  in_rd;
    logic [15:0] in_ctrl;
    logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_imm;
    logic [4:0]  ex_rd;
    logic [15:0] ex_ctrl;
    logic [3:0]  stall_cnt;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        inValid;
        logic [31:0] pc;
        logic        exReady;
        logic        expValid;
        logic        expReady;
        logic [31:0] expPc;
        logic [3:0]  expCnt;
    } vec_t;

    vec_t vecs[21];

    idex_pipe_reg #(.XLEN(32), .REGADDR_W(5), .CTRL_W(16), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_op_a(in_op_a), .in_op_b(in_op_b), .in_imm(in_imm),
        .in_rd(in_rd), .in_ctrl(in_ctrl),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    // Every payload field is derived from the pc so a single tag identifies the whole item.
    function automatic logic [15:0] ctrlOf(input logic [31:0] pc);
        return pc[15:0] ^ 16'h5A5A;
    endfunction

    task automatic applyStimulus(input logic rst, input logic fl, input logic inValid,
                                 input logic [31:0] pc, input logic exReady);
        reset    = rst;
        flush    = fl;
        in_valid = inValid;
        ex_ready = exReady;
        in_pc    = pc;
        in_op_a  = pc ^ 32'hA5A5_0000;
        in_op_b  = ~pc;
        in_imm   = pc + 32'h1000;
        in_rd    = pc[6:2];
        in_ctrl  = ctrlOf(pc);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic checkPayload(input string name, input logic [31:0] pc);
        checkOutput({name, "_pc"},   ex_pc,   pc);
        checkOutput({name, "_opa"},  ex_op_a, pc ^ 32'hA5A5_0000);
        checkOutput({name, "_opb"},  ex_op_b, ~pc);
        checkOutput({name, "_imm"},  ex_imm,  pc + 32'h1000);
        checkOutput({name, "_rd"},   {27'd0, ex_rd},   {27'd0, pc[6:2]});
        checkOutput({name, "_ctrl"}, {16'd0, ex_ctrl}, {16'd0, ctrlOf(pc)});
    endtask

    task automatic step(input logic rst, input logic fl, input logic inValid,
                        input logic [31:0] pc, input logic exReady);
        @(negedge clock);
        applyStimulus(rst, fl, inValid, pc, exReady);
        @(posedge clock);
        #1;
    endtask

    logic [31:0] q[$];
    logic [31:0] pcSeq;
    logic [31:0] presented;
    logic        acc, drn;

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);

        // rst fl inV pc exR | expValid expReady expPc expCnt
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,  4'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,  4'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h0,  4'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h0,  4'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h0,   1'b1, 1'b1, 1'b1, 32'h0,  4'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h4,   1'b1, 1'b1, 1'b1, 32'h4,  4'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h8,   1'b1, 1'b1, 1'b1, 32'h8,  4'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h0,  4'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h10,  1'b0, 1'b1, 1'b1, 32'h10, 4'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h14,  1'b0, 1'b1, 1'b0, 32'h10, 4'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h18,  1'b0, 1'b1, 1'b0, 32'h10, 4'd2};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h14, 4'd2};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h0,  4'd2};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h30,  1'b0, 1'b1, 1'b1, 32'h30, 4'd2};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h34,  1'b0, 1'b1, 1'b0, 32'h30, 4'd3};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h20,  1'b0, 1'b0, 1'b1, 32'h0,  4'd4};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h0,  4'd4};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 32'h50,  1'b0, 1'b1, 1'b1, 32'h50, 4'd4};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 32'h54,  1'b0, 1'b1, 1'b0, 32'h50, 4'd5};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 32'h58,  1'b0, 1'b0, 1'b0, 32'h0,  4'd0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h0,  4'd0};

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].rst, vecs[i].fl, vecs[i].inValid, vecs[i].pc, vecs[i].exReady);
            checkOutput($sformatf("vec%0d_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].expValid});
            checkOutput($sformatf("vec%0d_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].expReady});
            checkOutput($sformatf("vec%0d_cnt", i), {28'd0, stall_cnt}, {28'd0, vecs[i].expCnt});
            if (vecs[i].expValid) checkPayload($sformatf("vec%0d", i), vecs[i].expPc);
            if (vecs[i].rst) begin
                checkOutput($sformatf("vec%0d_rstpc", i), ex_pc, 32'h0);
                checkOutput($sformatf("vec%0d_rstctrl", i), {16'd0, ex_ctrl}, 32'h0);
            end
        end

        // Stall counter saturation, then a flush that must not clear it.
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        checkOutput("sat_load_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("sat_load_cnt", {28'd0, stall_cnt}, 32'd0);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput($sformatf("sat_cnt%0d", k), {28'd0, stall_cnt}, (k > 15) ? 32'd15 : 32'(k));
        end
        checkPayload("sat_hold", 32'h40);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("sat_flush_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("sat_flush_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("sat_flush_cnt", {28'd0, stall_cnt}, 32'd15);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("sat_after_cnt", {28'd0, stall_cnt}, 32'd15);

        // Randomized traffic against an in-order queue of accepted pcs.
        pcSeq = 32'h1000;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clock);
            presented = pcSeq;
            applyStimulus(1'b0, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 70,
                          pcSeq, $urandom_range(0, 99) < 60);
            pcSeq = pcSeq + 32'd4;
            #1;
            acc = in_valid & in_ready;
            drn = ex_valid & ex_ready;
            if (!in_ready) checkOutput("rnd_skid_without_out", {31'd0, ex_valid}, 32'd1);
            if (drn) begin
                if (q.size() > 0) begin
                    checkOutput("rnd_order_pc", ex_pc, q[0]);
                    checkOutput("rnd_order_ctrl", {16'd0, ex_ctrl}, {16'd0, ctrlOf(q[0])});
                    void'(q.pop_front());
                end else begin
                    checkOutput("rnd_extra", {31'd0, ex_valid}, 32'd0);
                end
            end
            @(posedge clock);
            if (flush) q.delete();
            else if (acc) q.push_back(presented);
            #1;
            checkOutput("rnd_valid", {31'd0, ex_valid}, {31'd0, q.size() > 0});
            checkOutput("rnd_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
